mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/ntru_mult_pkg.sv | 48 ++++
 rtl/ntru_haddr_gen.sv | 48 ++++
 rtl/mult_sched.sv | 162 ++++++++++++++++
 tb/tb_mult_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_mult_pkg.sv
// Shared definitions for the multiplication scheduler: width helpers,
// block-count derivation and the controller state encoding.
package ntru_mult_pkg;

  // Ceiling log2 of v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int gi = 0; gi < 31; gi++) begin
      if ((1 << gi) < v) r = gi + 1;
    end
    return r;
  endfunction

  // Number of bits needed to hold the value v, never less than 1.
  function automatic int bits_for(input int v);
    return (v < 1) ? 1 : clog2(v + 1);
  endfunction

  // Block count: lanes of width m covering a polynomial of length n.
  function automatic int calc_b(input int n, input int m);
    return (n + m - 1) / m;
  endfunction

  // Address width for coefficient indices 0..n-1.
  function automatic int calc_aw(input int n);
    return bits_for(n - 1);
  endfunction

  // Accumulator block index width for blocks 0..B-1.
  function automatic int calc_ew(input int n, input int m);
    return bits_for(calc_b(n, m) - 1);
  endfunction

  // Count width able to hold the value n.
  function automatic int calc_cw(input int n);
    return bits_for(n);
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    PASS  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ntru_haddr_gen.sv
// h base-address generator: walks (b*M - i) mod N across the blocks of a
// pass by repeated add-and-conditionally-subtract, so no multiplier or
// divider is needed. Assumes M <= N so a single subtraction suffices.
module ntru_haddr_gen
  import ntru_mult_pkg::*;
#(
  parameter int N = 11,
  parameter int M = 1,
  localparam int AW = calc_aw(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          step,
  output logic [AW-1:0] addr_h
);

  // Sum width covers the worst case (N-1) + M before reduction.
  localparam int SW = bits_for(N - 1 + M);

  logic [AW-1:0] addr_h_reg;
  logic [AW-1:0] addr_h_next;
  logic [SW-1:0] sum;

  // Next address: advance by M lanes and fold back into 0..N-1.
  always_comb begin
    sum         = SW'(addr_h_reg) + SW'(M);
    addr_h_next = AW'(sum);
    if (sum >= SW'(N)) begin
      addr_h_next = AW'(sum - SW'(N));
    end
  end

  // Address register: load the pass base, otherwise step once per block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_h_reg <= '0;
    end else if (load) begin
      addr_h_reg <= base;
    end else if (step) begin
      addr_h_reg <= addr_h_next;
    end
  end

  assign addr_h = addr_h_reg;

endmodule

// File: rtl/mult_sched.sv
// Sparse polynomial multiplication scheduler. Scans the r coefficients,
// skips zeros, and for every nonzero coefficient runs one accumulation
// pass of B blocks over the lanes, stopping after nnz nonzeros, after
// MAX_CYCLES passes or at the last coefficient.
module mult_sched
  import ntru_mult_pkg::*;
#(
  parameter int N          = 11,
  parameter int M          = 1,
  parameter int MAX_CYCLES = 7,
  localparam int AW = calc_aw(N),
  localparam int EW = calc_ew(N, M),
  localparam int CW = calc_cw(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] nnz,
  input  logic [1:0]    r,
  output logic [AW-1:0] addr_r,
  output logic [AW-1:0] addr_h,
  output logic [EW-1:0] addr_e,
  output logic          operate,
  output logic          busy,
  output logic          end_op,
  output logic [CW-1:0] passes,
  output logic          overflow
);

  localparam int B = calc_b(N, M);
  localparam logic [AW-1:0] LAST_I  = AW'(N - 1);
  localparam logic [EW-1:0] LAST_B  = EW'(B - 1);
  localparam logic [31:0]   MAX_C32 = 32'(MAX_CYCLES);

  state_t        state_reg;
  logic [AW-1:0] i_reg;
  logic [CW-1:0] k_reg;
  logic [EW-1:0] b_reg;
  logic [CW-1:0] passes_reg;
  logic          overflow_reg;
  logic          operate_reg;
  logic          busy_reg;
  logic          end_op_reg;

  logic          h_load;
  logic          h_step;
  logic [AW-1:0] h_base;
  logic          pass_last;
  logic          job_last;

  // Pass base (N - i) mod N is loaded as the controller leaves CHECK for
  // PASS, so block 0 already presents the right h index.
  always_comb begin
    h_load    = (state_reg == CHECK) && (r != 2'b00);
    h_step    = (state_reg == PASS);
    h_base    = (i_reg == '0) ? '0 : AW'(N) - i_reg;
    pass_last = (b_reg == LAST_B);
    job_last  = ((k_reg + CW'(1)) == nnz) ||
                ((32'(passes_reg) + 32'd1) == MAX_C32) ||
                (i_reg == LAST_I);
  end

  ntru_haddr_gen #(
    .N (N),
    .M (M)
  ) u_haddr_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (h_load),
    .base   (h_base),
    .step   (h_step),
    .addr_h (addr_h)
  );

  // Controller: state, scan/pass counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      i_reg        <= '0;
      k_reg        <= '0;
      b_reg        <= '0;
      passes_reg   <= '0;
      overflow_reg <= 1'b0;
      operate_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      end_op_reg   <= 1'b0;
    end else begin
      operate_reg <= 1'b0;
      end_op_reg  <= 1'b0;
      busy_reg    <= 1'b1;
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
          if (start) begin
            busy_reg     <= 1'b1;
            passes_reg   <= '0;
            i_reg        <= '0;
            k_reg        <= '0;
            b_reg        <= '0;
            overflow_reg <= (32'(nnz) > MAX_C32);
            if (nnz == '0) begin
              state_reg  <= DONE;
              end_op_reg <= 1'b1;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        FETCH: begin
          state_reg <= CHECK;
        end
        CHECK: begin
          if (r != 2'b00) begin
            state_reg   <= PASS;
            b_reg       <= '0;
            operate_reg <= 1'b1;
          end else if (i_reg == LAST_I) begin
            state_reg  <= DONE;
            end_op_reg <= 1'b1;
          end else begin
            i_reg     <= i_reg + AW'(1);
            state_reg <= FETCH;
          end
        end
        PASS: begin
          if (pass_last) begin
            b_reg      <= '0;
            k_reg      <= k_reg + CW'(1);
            passes_reg <= passes_reg + CW'(1);
            if (job_last) begin
              state_reg  <= DONE;
              end_op_reg <= 1'b1;
            end else begin
              i_reg     <= i_reg + AW'(1);
              state_reg <= FETCH;
            end
          end else begin
            b_reg       <= b_reg + EW'(1);
            operate_reg <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_r   = i_reg;
  assign addr_e   = b_reg;
  assign operate  = operate_reg;
  assign busy     = busy_reg;
  assign end_op   = end_op_reg;
  assign passes   = passes_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: two instances (M=1 and M=4) share the
// job stream; a reference model predicts every operate cycle and the job
// result, and per-instance monitors compare as the DUTs produce them.
module tb_mult_sched;
  import ntru_mult_pkg::*;

  localparam int N    = 11;
  localparam int MAXC = 7;
  localparam int AW_T = calc_aw(N);
  localparam int CW_T = calc_cw(N);

  typedef struct {
    int e;
    int h;
    int r;
  } op_t;

  typedef struct {
    int passes;
    int ovf;
    int end_cyc;
  } res_t;

  logic            clk;
  logic            reset;
  logic [1:0]      start_v;
  logic [CW_T-1:0] nnz;
  logic [1:0]      mem [0:N-1];

  logic [AW_T-1:0] ar_v   [2];
  logic [AW_T-1:0] ah_v   [2];
  int              ae_v   [2];
  logic            op_v   [2];
  logic            busy_v [2];
  logic            eo_v   [2];
  logic [CW_T-1:0] ps_v   [2];
  logic            ov_v   [2];

  op_t  exp_op  [2][$];
  res_t exp_res [2][$];
  int   held_passes [2];
  int   held_ovf    [2];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    localparam int MG  = (gi == 0) ? 1 : 4;
    localparam int EWG = calc_ew(N, MG);
    logic [EWG-1:0] ae;
    logic [1:0]     r_q;

    mult_sched #(.N(N), .M(MG), .MAX_CYCLES(MAXC)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[gi]),
      .nnz      (nnz),
      .r        (r_q),
      .addr_r   (ar_v[gi]),
      .addr_h   (ah_v[gi]),
      .addr_e   (ae),
      .operate  (op_v[gi]),
      .busy     (busy_v[gi]),
      .end_op   (eo_v[gi]),
      .passes   (ps_v[gi]),
      .overflow (ov_v[gi])
    );

    assign ae_v[gi] = int'(ae);

    // r memory with one-cycle registered read
    always @(posedge clk) r_q <= mem[ar_v[gi]];

    // monitor: compare each operate cycle and each job completion
    initial begin
      op_t  o;
      res_t rs;
      forever begin
        @(negedge clk);
        if (reset) begin
          if (op_v[gi]) begin
            chk($sformatf("dut%0d operate expected", gi), (exp_op[gi].size() > 0) ? 1 : 0, 1);
            if (exp_op[gi].size() > 0) begin
              o = exp_op[gi].pop_front();
              chk($sformatf("dut%0d addr_e", gi), ae_v[gi], o.e);
              chk($sformatf("dut%0d addr_h", gi), int'(ah_v[gi]), o.h);
              chk($sformatf("dut%0d addr_r in pass", gi), int'(ar_v[gi]), o.r);
            end
          end
          if (eo_v[gi]) begin
            chk($sformatf("dut%0d end_op expected", gi), (exp_res[gi].size() > 0) ? 1 : 0, 1);
            if (exp_res[gi].size() > 0) begin
              rs = exp_res[gi].pop_front();
              chk($sformatf("dut%0d passes", gi), int'(ps_v[gi]), rs.passes);
              chk($sformatf("dut%0d overflow", gi), int'(ov_v[gi]), rs.ovf);
              chk($sformatf("dut%0d end_op cycle", gi), cyc, rs.end_cyc);
              chk($sformatf("dut%0d operates left", gi), exp_op[gi].size(), 0);
            end
          end
          if (busy_v[gi]) begin
            chk($sformatf("dut%0d addr_r in range", gi), (int'(ar_v[gi]) <= N - 1) ? 1 : 0, 1);
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 2'b00;
  endtask

  task automatic flush();
    for (int c = 0; c < 2; c++) begin
      exp_op[c].delete();
      exp_res[c].delete();
    end
  endtask

  // Predict the job from the coefficient list, then pulse start on both DUTs.
  task automatic issue(input int nz);
    op_t  o;
    res_t rs;
    int   k, p, lat, bb, mm;
    bit   stop;
    nnz = CW_T'(nz);
    for (int c = 0; c < 2; c++) begin
      mm   = (c == 0) ? 1 : 4;
      bb   = (N + mm - 1) / mm;
      k    = 0;
      p    = 0;
      lat  = 1;
      stop = (nz == 0);
      for (int i = 0; i < N; i++) begin
        if (!stop) begin
          lat += 2;
          if (mem[i] != 2'b00) begin
            for (int b = 0; b < bb; b++) begin
              o.e = b;
              o.h = (((b * mm - i) % N) + N) % N;
              o.r = i;
              exp_op[c].push_back(o);
            end
            lat += bb;
            k++;
            p++;
            if (k == nz || p == MAXC) stop = 1'b1;
          end
        end
      end
      rs.passes  = p;
      rs.ovf     = (nz > MAXC) ? 1 : 0;
      rs.end_cyc = cyc + lat;
      exp_res[c].push_back(rs);
      held_passes[c] = p;
      held_ovf[c]    = rs.ovf;
    end
    start_v = 2'b11;
    @(negedge clk);
    start_v = 2'b00;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("dut%0d overflow after start", c), int'(ov_v[c]), held_ovf[c]);
      chk($sformatf("dut%0d passes cleared at start", c), int'(ps_v[c]), 0);
    end
  endtask

  task automatic wait_idle();
    bit done_f;
    done_f = 1'b0;
    for (int n = 0; n < 3000 && !done_f; n++) begin
      @(negedge clk);
      if (exp_res[0].size() == 0 && exp_res[1].size() == 0 && !busy_v[0] && !busy_v[1])
        done_f = 1'b1;
    end
    chk("job finished within budget", int'(done_f), 1);
    if (!done_f) begin
      reset = 1'b0;
      @(negedge clk);
      flush();
      reset = 1'b1;
      @(negedge clk);
    end else begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("dut%0d passes held", c), int'(ps_v[c]), held_passes[c]);
        chk($sformatf("dut%0d overflow held", c), int'(ov_v[c]), held_ovf[c]);
      end
    end
  endtask

  task automatic run_job(input int nz);
    issue(nz);
    wait_idle();
  endtask

  task automatic wait_op0();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      if (op_v[0]) seen = 1'b1;
    end
    chk("dut0 reached pass", int'(seen), 1);
  endtask

  task automatic check_idle_zero(input string tag);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s dut%0d addr_r", tag, c), int'(ar_v[c]), 0);
      chk($sformatf("%s dut%0d addr_h", tag, c), int'(ah_v[c]), 0);
      chk($sformatf("%s dut%0d addr_e", tag, c), ae_v[c], 0);
      chk($sformatf("%s dut%0d operate", tag, c), int'(op_v[c]), 0);
      chk($sformatf("%s dut%0d busy", tag, c), int'(busy_v[c]), 0);
      chk($sformatf("%s dut%0d end_op", tag, c), int'(eo_v[c]), 0);
      chk($sformatf("%s dut%0d passes", tag, c), int'(ps_v[c]), 0);
      chk($sformatf("%s dut%0d overflow", tag, c), int'(ov_v[c]), 0);
    end
  endtask

  initial begin
    int nz;
    bit seen;
    reset   = 1'b0;
    start_v = 2'b00;
    nnz     = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // nnz = 0: straight to DONE, no operate
    clear_mem();
    run_job(0);
    // single nonzero at index 3
    clear_mem();
    mem[3] = 2'd1;
    run_job(1);
    // single nonzero at index 2, value 2
    clear_mem();
    mem[2] = 2'd2;
    run_job(1);
    // nine nonzeros, capped at MAX_CYCLES passes, overflow flagged
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = 2'(1 + (i % 3));
    run_job(9);
    // only the last coefficient nonzero
    clear_mem();
    mem[10] = 2'd3;
    run_job(1);

    // start pulsed while both DUTs are mid-job is ignored
    clear_mem();
    mem[1] = 2'd1;
    mem[4] = 2'd2;
    mem[6] = 2'd3;
    issue(3);
    wait_op0();
    start_v = 2'b11;
    @(negedge clk);
    start_v = 2'b00;
    wait_idle();

    // start in the end_op cycle is ignored
    clear_mem();
    mem[7] = 2'd1;
    issue(1);
    seen = 1'b0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      if (eo_v[0]) seen = 1'b1;
    end
    chk("dut0 end_op seen", int'(seen), 1);
    start_v = 2'b01;
    @(negedge clk);
    start_v = 2'b00;
    chk("dut0 busy after start during end_op", int'(busy_v[0]), 0);
    wait_idle();

    // reset in the middle of a pass aborts without end_op
    clear_mem();
    mem[5] = 2'd1;
    issue(1);
    wait_op0();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    flush();
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("dut0 idle after abort", int'(busy_v[0]), 0);
    chk("dut1 idle after abort", int'(busy_v[1]), 0);

    // randomized jobs
    for (int t = 0; t < 40; t++) begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        mem[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (mem[i] != 2'b00) cnt++;
      end
      nz = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : cnt;
      run_job(nz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
